rd_bus_burst: RTL and testbench

RD_BUS_BURST -- requirements
Module: rd_bus_burst

---
 rtl/rd_bus_pkg.sv | 37 +++
 rtl/tx_byte_sender.sv | 55 +++++
 rtl/rd_bus_burst.sv | 133 +++++++++++++
 tb/tb_rd_bus_burst.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_bus_pkg.sv
// Shared definitions for the burst-read command block: state encodings,
// opcode class, timeout fill byte and the default acknowledge timeout.
package rd_bus_pkg;

    // Main sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ECHO     = 3'd1,
        ST_ECHO_GAP = 3'd2,
        ST_READ     = 3'd3,
        ST_SEND     = 3'd4,
        ST_SEND_GAP = 3'd5
    } state_t;

    // Byte sender states: wait for the transmitter, strobe once, rest one cycle.
    typedef enum logic [1:0] {
        SND_IDLE  = 2'd0,
        SND_PULSE = 2'd1,
        SND_GAP   = 2'd2
    } snd_state_t;

    // Top two opcode bits that identify a burst-read command.
    localparam logic [1:0] OPC_CLASS = 2'b01;

    // Byte reported in place of data when the bus never acknowledges.
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    // Cycles to wait for bus_ack before giving up on a read.
    localparam int DEFAULT_ACK_TIMEOUT = 255;

    // Address of beat idx in a burst; the 16-bit sum wraps past 0xFFFF.
    function automatic logic [15:0] read_addr(input logic [15:0] base,
                                              input logic [4:0]  idx);
        return base + {11'd0, idx};
    endfunction

endpackage

// File: rtl/tx_byte_sender.sv
// One-byte transmit handshake: waits for tx_busy low, raises tx_en for a
// single cycle with the byte on tx_data, then rests one cycle so the
// transmitter's busy flag is never sampled right after the strobe.
module tx_byte_sender (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       sent
);
    import rd_bus_pkg::*;

    snd_state_t state;
    snd_state_t state_next;
    logic       fire;

    // Launch a byte only from rest, when asked and the transmitter is free.
    assign fire = (state == SND_IDLE) && start && !tx_busy;

    // Sender state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SND_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the wait / pulse / gap sequence.
    always_comb begin
        state_next = state;
        case (state)
            SND_IDLE:  if (fire) state_next = SND_PULSE;
            SND_PULSE: state_next = SND_GAP;
            SND_GAP:   state_next = SND_IDLE;
            default:   state_next = SND_IDLE;
        endcase
    end

    // Hold the byte being sent so tx_data is stable during the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data <= 8'h00;
        end else if (fire) begin
            tx_data <= tx_byte;
        end
    end

    assign tx_en = (state == SND_PULSE);
    assign sent  = (state == SND_PULSE);

endmodule

// File: rtl/rd_bus_burst.sv
// Burst-read command engine: accepts a 01xx_LLLL opcode, echoes it to the
// serial transmitter, then reads LLLL+1 consecutive bus bytes starting at
// addr and forwards each one. A read that is never acknowledged is replaced
// by 0xFF and flags err, and the burst carries on.
module rd_bus_burst #(
    parameter int ACK_TIMEOUT = rd_bus_pkg::DEFAULT_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  opcode,
    input  logic        en,
    input  logic [15:0] addr,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_busy,
    output logic        busy,
    output logic        err
);
    import rd_bus_pkg::*;

    localparam int             CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state;
    state_t        state_next;

    logic [15:0]   base_q;
    logic [4:0]    len_q;
    logic [4:0]    idx_q;
    logic [7:0]    opcode_q;
    logic [7:0]    data_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          more;
    logic          timeout;
    logic          enter_read;
    logic          snd_start;
    logic          snd_sent;
    logic [7:0]    snd_byte;

    // Shared byte sender, used for the opcode echo and for every data byte.
    tx_byte_sender u_sender (
        .clk     (clk),
        .rst     (rst),
        .start   (snd_start),
        .tx_byte (snd_byte),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_en   (tx_en),
        .sent    (snd_sent)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control decode and next-state logic for the echo / read / send loop.
    always_comb begin
        accept     = (state == ST_IDLE) && en && (opcode[7:6] == OPC_CLASS);
        more       = (idx_q < len_q);
        timeout    = (cnt_q == CNT_LAST);
        enter_read = (state == ST_ECHO_GAP) || ((state == ST_SEND_GAP) && more);
        snd_start  = (state == ST_ECHO) || (state == ST_SEND);
        snd_byte   = (state == ST_ECHO) ? opcode_q : data_q;
        state_next = state;
        case (state)
            ST_IDLE:     if (accept) state_next = ST_ECHO;
            ST_ECHO:     if (snd_sent) state_next = ST_ECHO_GAP;
            ST_ECHO_GAP: state_next = ST_READ;
            ST_READ:     if (bus_ack || timeout) state_next = ST_SEND;
            ST_SEND:     if (snd_sent) state_next = ST_SEND_GAP;
            ST_SEND_GAP: state_next = more ? ST_READ : ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Command latch, bus read handshake with timeout, and beat counting.
    // Ack is tested before timeout so a late ack in the last cycle still wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= 16'h0000;
            len_q    <= 5'd0;
            idx_q    <= 5'd0;
            opcode_q <= 8'h00;
            data_q   <= 8'h00;
            cnt_q    <= '0;
            bus_addr <= 16'h0000;
            bus_rd   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                base_q   <= addr;
                len_q    <= {1'b0, opcode[3:0]} + 5'd1;
                idx_q    <= 5'd0;
                opcode_q <= opcode;
                err      <= 1'b0;
            end
            if (enter_read) begin
                bus_addr <= read_addr(base_q, idx_q);
                bus_rd   <= 1'b1;
                cnt_q    <= '0;
            end
            if (state == ST_READ) begin
                if (bus_ack) begin
                    data_q <= bus_rdata;
                    bus_rd <= 1'b0;
                end else if (timeout) begin
                    data_q <= TIMEOUT_FILL;
                    err    <= 1'b1;
                    bus_rd <= 1'b0;
                end else begin
                    cnt_q  <= cnt_q + 1'b1;
                end
            end
            if ((state == ST_SEND) && snd_sent) begin
                idx_q <= idx_q + 5'd1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rd_bus_burst.sv
// Directed bench for rd_bus_burst with a scripted bus responder and a
// transmit/read logger; each task checks its own scenario.
module tb_rd_bus_burst;

    logic        clk;
    logic        rst;
    logic [7:0]  opcode;
    logic        en;
    logic [15:0] addr;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy;
    logic        busy;
    logic        err;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  tx_log[$];
    logic [15:0] addr_log[$];
    int          len_log[$];
    int          dbl_pulses = 0;

    int tx_base   = 0;
    int addr_base = 0;
    int len_base  = 0;
    int dbl_base  = 0;

    int          ack_delay = 0;
    logic [7:0]  rdata_tbl[16];

    rd_bus_burst #(.ACK_TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .en        (en),
        .addr      (addr),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Logger and bus responder, sampling on the falling edge.
    initial begin
        logic tx_prev;
        logic rd_prev;
        int   rd_cycles;
        int   k;
        tx_prev   = 1'b0;
        rd_prev   = 1'b0;
        rd_cycles = 0;
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                tx_log.push_back(tx_data);
                if (tx_prev) dbl_pulses++;
            end
            tx_prev = (tx_en === 1'b1);
            if (bus_rd === 1'b1) begin
                if (!rd_prev) begin
                    addr_log.push_back(bus_addr);
                    rd_cycles = 0;
                end
                rd_cycles++;
                if (ack_delay != 0 && rd_cycles == ack_delay) begin
                    k = addr_log.size() - 1 - addr_base;
                    bus_ack   = 1'b1;
                    bus_rdata = rdata_tbl[k[3:0]];
                end else begin
                    bus_ack = 1'b0;
                end
            end else begin
                if (rd_prev) len_log.push_back(rd_cycles);
                bus_ack   = 1'b0;
                rd_cycles = 0;
            end
            rd_prev = (bus_rd === 1'b1);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int tx_cnt();
        return tx_log.size() - tx_base;
    endfunction

    function automatic int rd_cnt();
        return addr_log.size() - addr_base;
    endfunction

    function automatic logic [7:0] tx_at(int i);
        if (tx_base + i < tx_log.size()) return tx_log[tx_base + i];
        return 8'hxx;
    endfunction

    function automatic logic [15:0] addr_at(int i);
        if (addr_base + i < addr_log.size()) return addr_log[addr_base + i];
        return 16'hxxxx;
    endfunction

    function automatic int len_at(int i);
        if (len_base + i < len_log.size()) return len_log[len_base + i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        tx_base   = tx_log.size();
        addr_base = addr_log.size();
        len_base  = len_log.size();
        dbl_base  = dbl_pulses;
    endtask

    task automatic issue_cmd(input logic [7:0] op, input logic [15:0] a);
        opcode = op;
        addr   = a;
        en     = 1'b1;
        tick();
        en     = 1'b0;
        opcode = 8'h00;
        addr   = 16'h0000;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus_rd !== 1'b0) begin fails++; $display("[TB] FAIL reset_bus_rd: got %b, expected 0", bus_rd); end
        checks++; if (tx_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_en: got %b, expected 0", tx_en); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b, expected 0", err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (bus_addr !== 16'h0000) begin fails++; $display("[TB] FAIL reset_bus_addr: got %h, expected 0000", bus_addr); end
        checks++; if (tx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_tx_data: got %h, expected 00", tx_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        mark();
        ack_delay    = 3;
        rdata_tbl[0] = 8'h5A;
        issue_cmd(8'h40, 16'h1234);
        wait_idle("single", 200);
        checks++; if (tx_cnt() !== 2) begin fails++; $display("[TB] FAIL single_tx_count: got %0d, expected 2", tx_cnt()); end
        checks++; if (tx_at(0) !== 8'h40) begin fails++; $display("[TB] FAIL single_echo: got %h, expected 40", tx_at(0)); end
        checks++; if (tx_at(1) !== 8'h5A) begin fails++; $display("[TB] FAIL single_data: got %h, expected 5a", tx_at(1)); end
        checks++; if (rd_cnt() !== 1) begin fails++; $display("[TB] FAIL single_rd_count: got %0d, expected 1", rd_cnt()); end
        checks++; if (addr_at(0) !== 16'h1234) begin fails++; $display("[TB] FAIL single_addr: got %h, expected 1234", addr_at(0)); end
        checks++; if (len_at(0) !== 3) begin fails++; $display("[TB] FAIL single_rd_len: got %0d, expected 3", len_at(0)); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL single_err: got %b, expected 0", err); end
    endtask

    task automatic test_burst_wrap();
        mark();
        ack_delay    = 2;
        rdata_tbl[0] = 8'h11;
        rdata_tbl[1] = 8'h22;
        rdata_tbl[2] = 8'h33;
        issue_cmd(8'h42, 16'hFFFE);
        wait_idle("wrap", 300);
        checks++; if (tx_cnt() !== 4) begin fails++; $display("[TB] FAIL wrap_tx_count: got %0d, expected 4", tx_cnt()); end
        checks++; if (rd_cnt() !== 3) begin fails++; $display("[TB] FAIL wrap_rd_count: got %0d, expected 3", rd_cnt()); end
        checks++; if (addr_at(0) !== 16'hFFFE) begin fails++; $display("[TB] FAIL wrap_addr0: got %h, expected fffe", addr_at(0)); end
        checks++; if (addr_at(1) !== 16'hFFFF) begin fails++; $display("[TB] FAIL wrap_addr1: got %h, expected ffff", addr_at(1)); end
        checks++; if (addr_at(2) !== 16'h0000) begin fails++; $display("[TB] FAIL wrap_addr2: got %h, expected 0000", addr_at(2)); end
        checks++; if (tx_at(0) !== 8'h42) begin fails++; $display("[TB] FAIL wrap_echo: got %h, expected 42", tx_at(0)); end
        checks++; if (tx_at(2) !== 8'h22) begin fails++; $display("[TB] FAIL wrap_data1: got %h, expected 22", tx_at(2)); end
        checks++; if (tx_at(3) !== 8'h33) begin fails++; $display("[TB] FAIL wrap_data2: got %h, expected 33", tx_at(3)); end
        checks++; if (bus_addr !== 16'h0000) begin fails++; $display("[TB] FAIL wrap_addr_hold: got %h, expected 0000", bus_addr); end
    endtask

    task automatic test_timeout();
        mark();
        ack_delay = 0;
        issue_cmd(8'h41, 16'h0100);
        wait_idle("timeout", 300);
        checks++; if (tx_cnt() !== 3) begin fails++; $display("[TB] FAIL timeout_tx_count: got %0d, expected 3", tx_cnt()); end
        checks++; if (tx_at(0) !== 8'h41) begin fails++; $display("[TB] FAIL timeout_echo: got %h, expected 41", tx_at(0)); end
        checks++; if (tx_at(1) !== 8'hFF) begin fails++; $display("[TB] FAIL timeout_fill0: got %h, expected ff", tx_at(1)); end
        checks++; if (tx_at(2) !== 8'hFF) begin fails++; $display("[TB] FAIL timeout_fill1: got %h, expected ff", tx_at(2)); end
        checks++; if (len_at(0) !== 8) begin fails++; $display("[TB] FAIL timeout_rd_len0: got %0d, expected 8", len_at(0)); end
        checks++; if (len_at(1) !== 8) begin fails++; $display("[TB] FAIL timeout_rd_len1: got %0d, expected 8", len_at(1)); end
        checks++; if (addr_at(1) !== 16'h0101) begin fails++; $display("[TB] FAIL timeout_addr1: got %h, expected 0101", addr_at(1)); end
        checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL timeout_err: got %b, expected 1", err); end
        repeat (5) tick();
        checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL timeout_err_sticky: got %b, expected 1", err); end
    endtask

    task automatic test_ack_at_timeout();
        mark();
        ack_delay    = 8;
        rdata_tbl[0] = 8'h33;
        issue_cmd(8'h40, 16'h2000);
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL race_err_cleared: got %b, expected 0", err); end
        wait_idle("race", 200);
        checks++; if (tx_at(1) !== 8'h33) begin fails++; $display("[TB] FAIL race_data: got %h, expected 33", tx_at(1)); end
        checks++; if (len_at(0) !== 8) begin fails++; $display("[TB] FAIL race_rd_len: got %0d, expected 8", len_at(0)); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL race_err: got %b, expected 0", err); end
    endtask

    task automatic test_ignored();
        mark();
        issue_cmd(8'h80, 16'h1111);
        issue_cmd(8'hC0, 16'h2222);
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ignore_busy: got %b, expected 0", busy); end
        checks++; if (tx_cnt() + rd_cnt() !== 0) begin fails++; $display("[TB] FAIL ignore_traffic: got %0d events, expected 0", tx_cnt() + rd_cnt()); end
        ack_delay    = 2;
        rdata_tbl[0] = 8'h9C;
        issue_cmd(8'h40, 16'h5000);
        issue_cmd(8'h4F, 16'hAAAA);
        tick();
        issue_cmd(8'h4F, 16'hAAAA);
        wait_idle("ignore", 200);
        checks++; if (tx_cnt() !== 2) begin fails++; $display("[TB] FAIL ignore_busy_tx_count: got %0d, expected 2", tx_cnt()); end
        checks++; if (rd_cnt() !== 1) begin fails++; $display("[TB] FAIL ignore_busy_rd_count: got %0d, expected 1", rd_cnt()); end
        checks++; if (addr_at(0) !== 16'h5000) begin fails++; $display("[TB] FAIL ignore_busy_addr: got %h, expected 5000", addr_at(0)); end
        checks++; if (tx_at(1) !== 8'h9C) begin fails++; $display("[TB] FAIL ignore_busy_data: got %h, expected 9c", tx_at(1)); end
    endtask

    task automatic test_backpressure();
        mark();
        tx_busy      = 1'b1;
        ack_delay    = 1;
        rdata_tbl[0] = 8'h77;
        issue_cmd(8'h40, 16'h3000);
        repeat (20) tick();
        checks++; if (tx_cnt() !== 0) begin fails++; $display("[TB] FAIL bp_held_tx: got %0d pulses, expected 0", tx_cnt()); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL bp_held_busy: got %b, expected 1", busy); end
        tx_busy = 1'b0;
        wait_idle("bp", 200);
        checks++; if (tx_cnt() !== 2) begin fails++; $display("[TB] FAIL bp_tx_count: got %0d, expected 2", tx_cnt()); end
        checks++; if (tx_at(0) !== 8'h40) begin fails++; $display("[TB] FAIL bp_echo: got %h, expected 40", tx_at(0)); end
        checks++; if (tx_at(1) !== 8'h77) begin fails++; $display("[TB] FAIL bp_data: got %h, expected 77", tx_at(1)); end
        checks++; if (dbl_pulses - dbl_base !== 0) begin fails++; $display("[TB] FAIL bp_pulse_width: got %0d long pulses, expected 0", dbl_pulses - dbl_base); end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        mark();
        ack_delay = 0;
        issue_cmd(8'h4F, 16'h4000);
        n = 0;
        while (bus_rd !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++; if (bus_rd !== 1'b1) begin fails++; $display("[TB] FAIL midrst_reach_read: bus_rd=%b, expected 1", bus_rd); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (bus_rd !== 1'b0) begin fails++; $display("[TB] FAIL midrst_bus_rd: got %b, expected 0", bus_rd); end
        checks++; if (tx_en !== 1'b0) begin fails++; $display("[TB] FAIL midrst_tx_en: got %b, expected 0", tx_en); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
        rst = 1'b0;
        tick();
        mark();
        repeat (60) tick();
        checks++; if (tx_cnt() + rd_cnt() !== 0) begin fails++; $display("[TB] FAIL midrst_no_resume: got %0d events, expected 0", tx_cnt() + rd_cnt()); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_stay_idle: got %b, expected 0", busy); end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        opcode  = 8'h00;
        addr    = 16'h0000;
        tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) rdata_tbl[i] = 8'h00;
        test_reset();
        test_single_read();
        test_burst_wrap();
        test_timeout();
        test_ack_at_timeout();
        test_ignored();
        test_backpressure();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
